// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: state encoding and default width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

endpackage

// File: rtl/four_bit_restoring_divider_addsub.sv
// Ripple-carry adder/subtractor. add_sub=1 subtracts by inverting b and
// injecting a carry-in of 1 (two's complement).
module addsub_unit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         add_sub,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  assign b_eff    = b ^ {N{add_sub}};
  assign carry[0] = add_sub;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    assign sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign carry_out = carry[N];

endmodule

// File: rtl/four_bit_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; results from the last division held
//   S_CALC   | shift-and-subtract iterations, busy=1
//   S_FINISH | one-cycle done pulse; a new start is accepted here too
module four_bit_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                STEP_W    = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [STEP_W-1:0] step_q;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  d_q;

  logic [WIDTH:0]    rs;
  logic [WIDTH:0]    t;
  logic              sub_cout;
  logic              neg;
  logic [WIDTH-1:0]  r_next;
  logic [WIDTH-1:0]  q_next;
  logic              is_last;
  logic              accept;

  // The partial remainder never reaches D, so R only needs WIDTH bits; the
  // extra top bit of Rs/T exists purely to carry the sign of the trial.
  assign rs = {r_q, q_q[WIDTH-1]};

  addsub_unit #(.N(WIDTH + 1)) u_sub (
    .a         (rs),
    .b         ({1'b0, d_q}),
    .add_sub   (1'b1),
    .sum       (t),
    .carry_out (sub_cout)
  );

  // Sign bit and missing carry both indicate a borrow (Rs < D).
  assign neg     = t[WIDTH] | ~sub_cout;
  assign r_next  = neg ? rs[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_next  = {q_q[WIDTH-2:0], ~neg};
  assign is_last = (step_q == LAST_STEP);
  assign accept  = start && ((state == S_IDLE) || (state == S_FINISH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start is ignored while calculating.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start) next_state = (divisor == '0) ? S_FINISH : S_CALC;
        else       next_state = S_IDLE;
      end
      S_CALC:  if (is_last) next_state = S_FINISH;
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_CALC:   busy = 1'b1;
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers that only
  // change when entering FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q      <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_q    <= dividend;
      d_q    <= divisor;
      r_q    <= '0;
      step_q <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == S_CALC) begin
      r_q    <= r_next;
      q_q    <= q_next;
      step_q <= step_q + 1'b1;
      if (is_last) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_restoring_divider.sv
// Directed testbench for four_bit_restoring_divider (WIDTH=4).
module tb_four_bit_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  four_bit_restoring_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #10 clk = ~clk;

  // Issues one start pulse and waits for done; returns what was observed.
  // lat counts clock edges after the accepting edge until done is visible.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int bcnt,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic z, output bit to);
    lat = 0; bcnt = 0; to = 1'b1; q = '0; r = '0; z = 1'b0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        to = 1'b0; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
      if (busy) bcnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_13_3();
    int lat, bcnt; logic [3:0] q, r; logic z; bit to;
    do_div(4'd13, 4'd3, lat, bcnt, q, r, z, to);
    checks++;
    if (to) begin errors++; $display("FAIL div13_3_timeout: no done within 20 cycles"); end
    checks++;
    if (bcnt !== 4 || lat !== 4) begin
      errors++;
      $display("FAIL div13_3_latency: got busy=%0d lat=%0d, want busy=4 lat=4", bcnt, lat);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL div13_3_result: got q=%0d r=%0d z=%b, want q=4 r=1 z=0", q, r, z);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL div13_3_after_done: got done=%b busy=%b q=%0d r=%0d, want done=0 busy=0 q=4 r=1",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_edge_values();
    int lat, bcnt; logic [3:0] q, r; logic z; bit to;
    do_div(4'd15, 4'd1, lat, bcnt, q, r, z, to);
    checks++;
    if (to || q !== 4'd15 || r !== 4'd0 || z !== 1'b0) begin
      errors++;
      $display("FAIL div15_1: got q=%0d r=%0d z=%b to=%b, want q=15 r=0 z=0", q, r, z, to);
    end
    do_div(4'd3, 4'd7, lat, bcnt, q, r, z, to);
    checks++;
    if (to || q !== 4'd0 || r !== 4'd3 || z !== 1'b0) begin
      errors++;
      $display("FAIL div3_7: got q=%0d r=%0d z=%b to=%b, want q=0 r=3 z=0", q, r, z, to);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bcnt; logic [3:0] q, r; logic z; bit to;
    do_div(4'd9, 4'd0, lat, bcnt, q, r, z, to);
    checks++;
    if (to || lat !== 0 || bcnt !== 0) begin
      errors++;
      $display("FAIL div9_0_timing: got lat=%0d busy=%0d to=%b, want lat=0 busy=0", lat, bcnt, to);
    end
    checks++;
    if (q !== 4'd15 || r !== 4'd9 || z !== 1'b1) begin
      errors++;
      $display("FAIL div9_0_result: got q=%0d r=%0d z=%b, want q=15 r=9 z=1", q, r, z);
    end
    do_div(4'd8, 4'd2, lat, bcnt, q, r, z, to);
    checks++;
    if (to || q !== 4'd4 || r !== 4'd0 || z !== 1'b0) begin
      errors++;
      $display("FAIL div8_2_after_zero: got q=%0d r=%0d z=%b to=%b, want q=4 r=0 z=0", q, r, z, to);
    end
  endtask

  task automatic test_start_ignored_while_busy();
    int n; bit seen;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd0) begin
      errors++;
      $display("FAIL busy_hold: got busy=%b q=%0d r=%0d, want busy=1 q=4 r=0 (previous result held)",
               busy, quotient, remainder);
    end
    dividend = 4'd6; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (!seen || quotient !== 4'd3 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL ignored_start: got q=%0d r=%0d done_seen=%b, want q=3 r=2", quotient, remainder, seen);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bcnt; logic [3:0] q, r; logic z; bit to; bit saw_done;
    @(negedge clk);
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL no_done_after_abort: got done pulse, want none");
    end
    do_div(4'd11, 4'd2, lat, bcnt, q, r, z, to);
    checks++;
    if (to || q !== 4'd5 || r !== 4'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL div11_2_after_reset: got q=%0d r=%0d z=%b to=%b, want q=5 r=1 z=0", q, r, z, to);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit seen;
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    seen = 1'b0; n = 0;
    @(negedge clk);
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (!seen || quotient !== 4'd2 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL b2b_first: got q=%0d r=%0d done_seen=%b, want q=2 r=2", quotient, remainder, seen);
    end
    dividend = 4'd7; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0; n = 1;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (!seen || n !== 5) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 5", n);
    end
    checks++;
    if (quotient !== 4'd1 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got q=%0d r=%0d z=%b, want q=1 r=0 z=0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_sweep();
    int lat, bcnt; logic [3:0] q, r; logic z; bit to;
    int ia, ib;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), lat, bcnt, q, r, z, to);
        ia = a; ib = b;
        checks++;
        if (to) begin
          errors++;
          $display("FAIL sweep_timeout: %0d/%0d produced no done", ia, ib);
        end else if (ib == 0) begin
          if (q !== 4'd15 || int'(r) != ia || z !== 1'b1) begin
            errors++;
            $display("FAIL sweep_zero: %0d/0 got q=%0d r=%0d z=%b, want q=15 r=%0d z=1", ia, q, r, z, ia);
          end
        end else if (int'(q) * ib + int'(r) != ia || int'(r) >= ib || z !== 1'b0
                     || int'(q) != ia / ib) begin
          errors++;
          $display("FAIL sweep_invariant: %0d/%0d got q=%0d r=%0d z=%b, want q=%0d r=%0d z=0",
                   ia, ib, q, r, z, ia / ib, ia % ib);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_13_3();
    test_edge_values();
    test_div_by_zero();
    test_start_ignored_while_busy();
    test_reset_mid_calc();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
